// File: rtl/gomoku_pkg.sv
// Shared board constants, player encoding and cursor controller state type.
package gomoku_pkg;

   localparam int unsigned BOARD_N = 15;
   localparam int unsigned COORD_W = 4;

   localparam logic [COORD_W-1:0] CENTER = COORD_W'((BOARD_N - 1) / 2);

   localparam logic BLACK = 1'b0;
   localparam logic WHITE = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } cursor_state_e;

endpackage

// File: rtl/mod_wrap_counter.sv
// One cursor axis: counts modulo N with inc/dec and a center preset.
module mod_wrap_counter #(
   parameter int unsigned N     = 15,
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             dec,
   input  logic             load_center,
   output logic [WIDTH-1:0] value
);

   localparam logic [WIDTH-1:0] CTR  = WIDTH'((N - 1) / 2);
   localparam logic [WIDTH-1:0] LAST = WIDTH'(N - 1);

   logic [WIDTH-1:0] val_q, val_d;

   // Next value: center preset wins; opposing inc+dec hold the axis.
   always_comb begin
      val_d = val_q;
      if (load_center) begin
         val_d = CTR;
      end else if (inc && !dec) begin
         val_d = (val_q == LAST) ? '0 : val_q + WIDTH'(1);
      end else if (dec && !inc) begin
         val_d = (val_q == '0) ? LAST : val_q - WIDTH'(1);
      end
   end

   // Axis register, reset to center.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) val_q <= CTR;
      else      val_q <= val_d;
   end

   assign value = val_q;

endmodule

// File: rtl/gomoku_cursor.sv
// Cursor position, side-to-move tracking and placement request channel.
module gomoku_cursor
   import gomoku_pkg::*;
#(
   parameter int unsigned BOARD_N = gomoku_pkg::BOARD_N,
   parameter int unsigned COORD_W = gomoku_pkg::COORD_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               up_p,
   input  logic               down_p,
   input  logic               left_p,
   input  logic               right_p,
   input  logic               place_p,
   input  logic               new_game_p,
   input  logic               game_over,
   output logic [COORD_W-1:0] cur_x,
   output logic [COORD_W-1:0] cur_y,
   output logic               player,
   output logic               busy,
   output logic               place_valid,
   output logic [COORD_W-1:0] place_x,
   output logic [COORD_W-1:0] place_y,
   output logic               place_player,
   input  logic               place_ready,
   input  logic               resp_valid,
   input  logic               resp_ok
);

   cursor_state_e      state_q;
   logic               player_q;
   logic               busy_q;
   logic               valid_q;
   logic [COORD_W-1:0] px_q, py_q;
   logic               pp_q;

   logic in_idle, place_go, move_en, load_c;

   // Move gating: moves only in IDLE, and a new game or accepted place drops them.
   always_comb begin
      in_idle  = (state_q == IDLE);
      load_c   = in_idle && new_game_p;
      place_go = in_idle && !new_game_p && place_p && !game_over;
      move_en  = in_idle && !new_game_p && !place_go;
   end

   mod_wrap_counter #(.N(BOARD_N), .WIDTH(COORD_W)) u_x (
      .clk         (clk),
      .rst         (rst),
      .inc         (move_en && right_p),
      .dec         (move_en && left_p),
      .load_center (load_c),
      .value       (cur_x)
   );

   mod_wrap_counter #(.N(BOARD_N), .WIDTH(COORD_W)) u_y (
      .clk         (clk),
      .rst         (rst),
      .inc         (move_en && down_p),
      .dec         (move_en && up_p),
      .load_center (load_c),
      .value       (cur_y)
   );

   // Request FSM with registered outputs; reset drops any pending request at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         player_q <= BLACK;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
         px_q     <= '0;
         py_q     <= '0;
         pp_q     <= BLACK;
      end else begin
         case (state_q)
            IDLE: begin
               if (new_game_p) begin
                  player_q <= BLACK;
               end else if (place_go) begin
                  px_q    <= cur_x;
                  py_q    <= cur_y;
                  pp_q    <= player_q;
                  valid_q <= 1'b1;
                  busy_q  <= 1'b1;
                  state_q <= REQ;
               end
            end
            REQ: begin
               if (place_ready) begin
                  valid_q <= 1'b0;
                  state_q <= RESP;
               end
            end
            RESP: begin
               if (resp_valid) begin
                  if (resp_ok) player_q <= (player_q == BLACK) ? WHITE : BLACK;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: begin
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign player       = player_q;
   assign busy         = busy_q;
   assign place_valid  = valid_q;
   assign place_x      = px_q;
   assign place_y      = py_q;
   assign place_player = pp_q;

endmodule

// File: tb/tb_gomoku_cursor.sv
// Directed self-checking bench for gomoku_cursor.
module tb_gomoku_cursor;

   logic       clk = 1'b0;
   logic       rst;
   logic       up_p, down_p, left_p, right_p, place_p, new_game_p, game_over;
   logic [3:0] cur_x, cur_y, place_x, place_y;
   logic       player, busy, place_valid, place_player;
   logic       place_ready, resp_valid, resp_ok;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   gomoku_cursor #(.BOARD_N(15), .COORD_W(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .up_p         (up_p),
      .down_p       (down_p),
      .left_p       (left_p),
      .right_p      (right_p),
      .place_p      (place_p),
      .new_game_p   (new_game_p),
      .game_over    (game_over),
      .cur_x        (cur_x),
      .cur_y        (cur_y),
      .player       (player),
      .busy         (busy),
      .place_valid  (place_valid),
      .place_x      (place_x),
      .place_y      (place_y),
      .place_player (place_player),
      .place_ready  (place_ready),
      .resp_valid   (resp_valid),
      .resp_ok      (resp_ok)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_pulses();
      up_p = 0; down_p = 0; left_p = 0; right_p = 0; place_p = 0; new_game_p = 0;
      resp_valid = 0;
   endtask

   // u d l r place new_game, applied for exactly one edge
   task automatic pulse(input logic u, input logic d, input logic l, input logic r,
                        input logic p, input logic ng);
      up_p = u; down_p = d; left_p = l; right_p = r; place_p = p; new_game_p = ng;
      step();
      clear_pulses();
   endtask

   task automatic check_pos(input string name, input logic [3:0] ex, input logic [3:0] ey);
      n_cmp++;
      if (cur_x !== ex || cur_y !== ey) begin
         n_err++;
         $display("FAIL %s: cursor (%0d,%0d) expected (%0d,%0d)", name, cur_x, cur_y, ex, ey);
      end
   endtask

   task automatic test_reset();
      check_pos("reset_cursor", 4'd7, 4'd7);
      n_cmp++;
      if ({player, busy, place_valid, place_player} !== 4'b0000 || place_x !== 4'd0 || place_y !== 4'd0) begin
         n_err++;
         $display("FAIL reset_outputs: player=%b busy=%b valid=%b pp=%b px=%0d py=%0d expected all 0",
                  player, busy, place_valid, place_player, place_x, place_y);
      end
   endtask

   task automatic test_wrap_right();
      logic [3:0] exp_x;
      exp_x = 4'd7;
      for (int i = 0; i < 8; i++) begin
         pulse(0, 0, 0, 1, 0, 0);
         exp_x = (exp_x == 4'd14) ? 4'd0 : exp_x + 4'd1;
         check_pos("right_step", exp_x, 4'd7);
      end
   endtask

   task automatic test_left_and_opposing();
      pulse(0, 0, 1, 0, 0, 0);
      check_pos("left_wrap", 4'd14, 4'd7);
      for (int i = 0; i < 4; i++) pulse(0, 0, 0, 1, 0, 0);
      pulse(1, 0, 0, 0, 0, 0);
      pulse(1, 0, 0, 0, 0, 0);
      check_pos("reach_3_5", 4'd3, 4'd5);
      pulse(1, 0, 1, 1, 0, 0);
      check_pos("opposing_x_hold", 4'd3, 4'd4);
      pulse(1, 1, 0, 1, 0, 0);
      check_pos("opposing_y_hold", 4'd4, 4'd4);
      for (int i = 0; i < 4; i++) pulse(1, 0, 0, 0, 0, 0);
      pulse(1, 0, 0, 0, 0, 0);
      check_pos("up_wrap", 4'd4, 4'd14);
      pulse(0, 1, 0, 0, 0, 0);
      check_pos("down_wrap", 4'd4, 4'd0);
   endtask

   task automatic test_place_stall();
      pulse(0, 0, 0, 0, 0, 1);
      check_pos("new_game_center", 4'd7, 4'd7);
      pulse(0, 0, 0, 1, 1, 0);
      n_cmp++;
      if (place_valid !== 1'b1 || busy !== 1'b1 || place_x !== 4'd7 || place_y !== 4'd7 || place_player !== 1'b0) begin
         n_err++;
         $display("FAIL place_issue: valid=%b busy=%b px=%0d py=%0d pp=%b expected 1 1 7 7 0",
                  place_valid, busy, place_x, place_y, place_player);
      end
      check_pos("place_drops_move", 4'd7, 4'd7);
      for (int i = 0; i < 5; i++) begin
         pulse(1, 0, 0, 1, 1, 0);
         n_cmp++;
         if (place_valid !== 1'b1 || place_x !== 4'd7 || place_y !== 4'd7 || place_player !== 1'b0
             || cur_x !== 4'd7 || cur_y !== 4'd7) begin
            n_err++;
            $display("FAIL req_stall[%0d]: valid=%b px=%0d py=%0d pp=%b cur=(%0d,%0d) expected 1 7 7 0 (7,7)",
                     i, place_valid, place_x, place_y, place_player, cur_x, cur_y);
         end
      end
      place_ready = 1;
      step();
      place_ready = 0;
      n_cmp++;
      if (place_valid !== 1'b0 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL handshake: valid=%b busy=%b expected 0 1", place_valid, busy);
      end
   endtask

   task automatic test_resp();
      resp_valid = 1; resp_ok = 1;
      step();
      resp_valid = 0; resp_ok = 0;
      n_cmp++;
      if (player !== 1'b1 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL resp_ok: player=%b busy=%b expected 1 0", player, busy);
      end
      pulse(0, 0, 0, 0, 1, 0);
      n_cmp++;
      if (place_player !== 1'b1 || place_valid !== 1'b1) begin
         n_err++;
         $display("FAIL place_white: pp=%b valid=%b expected 1 1", place_player, place_valid);
      end
      place_ready = 1;
      step();
      place_ready = 0;
      resp_valid = 1; resp_ok = 0;
      step();
      resp_valid = 0;
      n_cmp++;
      if (player !== 1'b1 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL resp_reject: player=%b busy=%b expected 1 0", player, busy);
      end
   endtask

   task automatic test_game_over();
      game_over = 1;
      pulse(0, 0, 0, 1, 1, 0);
      game_over = 0;
      n_cmp++;
      if (place_valid !== 1'b0 || busy !== 1'b0 || cur_x !== 4'd8) begin
         n_err++;
         $display("FAIL game_over_place: valid=%b busy=%b cur_x=%0d expected 0 0 8", place_valid, busy, cur_x);
      end
      pulse(0, 1, 0, 1, 1, 1);
      n_cmp++;
      if (cur_x !== 4'd7 || cur_y !== 4'd7 || player !== 1'b0 || place_valid !== 1'b0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL new_game: cur=(%0d,%0d) player=%b valid=%b busy=%b expected (7,7) 0 0 0",
                  cur_x, cur_y, player, place_valid, busy);
      end
   endtask

   task automatic test_back_to_back();
      pulse(0, 0, 0, 0, 1, 0);
      place_ready = 1; resp_valid = 1; resp_ok = 1;
      step();
      place_ready = 0;
      n_cmp++;
      if (busy !== 1'b1 || player !== 1'b0 || place_valid !== 1'b0) begin
         n_err++;
         $display("FAIL early_resp_ignored: busy=%b player=%b valid=%b expected 1 0 0", busy, player, place_valid);
      end
      step();
      resp_valid = 0; resp_ok = 0;
      n_cmp++;
      if (busy !== 1'b0 || player !== 1'b1) begin
         n_err++;
         $display("FAIL fast_roundtrip: busy=%b player=%b expected 0 1", busy, player);
      end
      pulse(0, 0, 1, 0, 0, 0);
      check_pos("move_after_roundtrip", 4'd6, 4'd7);
   endtask

   task automatic test_reset_mid_req();
      pulse(0, 0, 0, 0, 1, 0);
      n_cmp++;
      if (place_valid !== 1'b1) begin
         n_err++;
         $display("FAIL pre_reset_req: valid=%b expected 1", place_valid);
      end
      #2 rst = 0;
      #1;
      n_cmp++;
      if (place_valid !== 1'b0 || busy !== 1'b0 || player !== 1'b0 || cur_x !== 4'd7 || place_x !== 4'd0) begin
         n_err++;
         $display("FAIL async_reset: valid=%b busy=%b player=%b cur_x=%0d px=%0d expected 0 0 0 7 0",
                  place_valid, busy, player, cur_x, place_x);
      end
      step();
      rst = 1;
      place_ready = 1; resp_valid = 1; resp_ok = 1;
      pulse(0, 0, 0, 1, 0, 0);
      place_ready = 0; resp_ok = 0;
      n_cmp++;
      if (cur_x !== 4'd8 || busy !== 1'b0 || player !== 1'b0) begin
         n_err++;
         $display("FAIL post_reset_move: cur_x=%0d busy=%b player=%b expected 8 0 0", cur_x, busy, player);
      end
   endtask

   initial begin
      rst = 0;
      game_over = 0; place_ready = 0; resp_ok = 0;
      clear_pulses();
      step();
      step();
      test_reset();
      rst = 1;
      step();
      test_wrap_right();
      test_left_and_opposing();
      test_place_stall();
      test_resp();
      test_game_over();
      test_back_to_back();
      test_reset_mid_req();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/gomoku_cursor.md
# gomoku_cursor

Cursor and move-request controller for the gomoku board. Consumes the single-cycle button pulses produced by the input edge-detect stage (up/down/left/right/place/new-game) and maintains the cursor position on the board. It tracks the side to move and issues placement requests to the game engine over a valid/ready request channel with a pulsed response.

## Interface
Parameters:
- BOARD_N, 15, board edge length; coordinates run 0..BOARD_N-1
- COORD_W, 4, coordinate width; must satisfy 2^COORD_W >= BOARD_N

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-low reset
- up_p, down_p, left_p, right_p  input  1 each  one-cycle move pulses
- place_p  input  1  one-cycle place pulse
- new_game_p  input  1  one-cycle new-game pulse
- game_over  input  1  level; high means the engine has declared a winner or draw
- cur_x, cur_y  output  COORD_W  cursor column and row
- player  output  1  side to move; 0 = black, 1 = white
- busy  output  1  high when state is not IDLE
- place_valid  output  1  placement request valid
- place_x, place_y  output  COORD_W  requested coordinate
- place_player  output  1  requesting side
- place_ready  input  1  engine accepts the request
- resp_valid  input  1  one-cycle engine response strobe
- resp_ok  input  1  qualified by resp_valid; 1 = stone placed, 0 = rejected (occupied)

## Operation
- States: IDLE, REQ, RESP.
- Reset values: state IDLE; cur_x = cur_y = (BOARD_N-1)/2, which is 7; player 0; place_valid 0; place_x/place_y/place_player 0; busy 0.
- IDLE, moves:
  - right_p increments cur_x; left_p decrements cur_x.
  - down_p increments cur_y; up_p decrements cur_y.
  - Both axes may move in the same cycle.
- Wrap-around: BOARD_N-1 +1 becomes 0; 0 -1 becomes BOARD_N-1. Arithmetic is modulo BOARD_N, never modulo 2^COORD_W.
- Opposing pulses on one axis in the same cycle (left+right, or up+down): that axis holds its value.
- IDLE, place_p with game_over low:
  - Latch place_x/place_y from the current cursor and place_player from player.
  - Assert place_valid and go to REQ.
  - Move pulses in the same cycle are dropped.
- place_p while game_over is high: ignored.
- new_game_p in IDLE:
  - Cursor returns to center and player to 0.
  - Takes priority over place_p and moves in the same cycle.
- REQ:
  - place_valid and place_x/place_y/place_player stay stable until a cycle with place_ready high.
  - On that edge: place_valid drops and the state goes to RESP.
  - game_over rising during REQ does not withdraw the request.
- RESP:
  - Wait for resp_valid, then return to IDLE.
  - If resp_ok is 1, player toggles on the same edge.
- All pulse inputs are ignored outside IDLE and are not queued.
- resp_valid outside RESP is ignored.
- resp_valid arriving in the same cycle as the REQ handshake is ignored; the engine responds at least one cycle after accepting.
- Reset asserted mid-request: everything returns to reset values immediately. place_valid drops asynchronously and no response is awaited.

## Timing
- Move pulse at edge t: cur_x/cur_y show the new value after edge t (latency 1).
- place_p sampled at edge t: place_valid and busy are high after edge t.
- Handshake at edge t+k (first edge with valid and ready both high): place_valid is low after that edge.
- Fastest round trip:
  - place_ready already high at edge t+1.
  - resp_valid at edge t+2.
  - Result: back in IDLE after edge t+2, and a new pulse is accepted at edge t+3.
- All outputs are registered; no combinational path from any input to any output.

## Structure
- Shared package gomoku_pkg holds:
  - BOARD_N and COORD_W constants
  - center coordinate constant
  - player encoding (BLACK = 0, WHITE = 1)
  - cursor state enum (IDLE, REQ, RESP)
- One sub-module, mod_wrap_counter (parameter N, WIDTH; inputs inc, dec, load_center), instantiated once per axis.
- The state machine and request registers live in gomoku_cursor.

## Test plan
- Reset then 8 right_p pulses -> cur_x goes 7,8,…,14,0; cur_y stays 7.
- From cur_x = 0: left_p -> 14. Same cycle left_p+right_p+up_p from (3,5) -> (3,4).
- place_p at (7,7), place_ready held low 5 cycles then high -> place_valid high for 6 cycles; place_x = place_y = 7 and place_player = 0 throughout; moves during this window are ignored.
- resp_valid with resp_ok = 1 -> player becomes 1 and busy drops. Repeat with resp_ok = 0 -> player unchanged.
- game_over high and place_p in IDLE -> place_valid stays 0. Then new_game_p -> cursor (7,7), player 0.
- Assert rst low while in REQ -> place_valid 0 and state IDLE immediately. After release, the first move pulse works normally.
